// File: rtl/serial_sub_if.sv
// serial_sub_if -- request/result bundle for the bit-serial subtractor.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow result flag.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             overflow;

  modport master (
    output start, a, b, b_in,
    input  busy, done, difference, b_out, overflow
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, difference, b_out, overflow
  );
`else
  modport master (
    output start, a, b, b_in,
    input  busy, done, difference, b_out
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, difference, b_out
  );
`endif
endinterface

// File: rtl/serial_sub.sv
// serial_sub -- bit-serial subtractor computing a - b - b_in, LSB first,
// one bit per clock. The result is published only on completion.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow flag.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus
);

  // Counter must be able to represent WIDTH itself (it reaches WIDTH on the last shift).
  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] diff_r;
  logic [CW-1:0]    cnt_r;
  logic             br_r;
  logic             bo_r;
  logic             busy_r;
  logic             done_r;
  logic             load_s;
  logic             shift_s;
  logic             last_s;
  logic             d_s;
  logic             br_next_s;
  logic [WIDTH-1:0] res_next_s;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_r;
  logic             b_msb_r;
  logic             ovf_r;
`endif

  // State register; reset forces IDLE regardless of the clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode: start is honoured only outside SHIFT.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_next_s = SHIFT;
        else           state_next_s = IDLE;
      end
      SHIFT: begin
        if (cnt_r == LAST) state_next_s = DONE;
        else               state_next_s = SHIFT;
      end
      DONE: begin
        if (bus.start) state_next_s = SHIFT;
        else           state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Control decode: operand load, bit shift, and final-bit strobe.
  always_comb begin
    load_s  = 1'b0;
    shift_s = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      IDLE:    load_s = bus.start;
      SHIFT: begin
        shift_s = 1'b1;
        last_s  = (cnt_r == LAST);
      end
      DONE:    load_s = bus.start;
      default: load_s = 1'b0;
    endcase
  end

  // One full-subtractor stage on the current LSBs; the new bit enters the result MSB.
  always_comb begin
    d_s        = a_r[0] ^ b_r[0] ^ br_r;
    br_next_s  = (~a_r[0] & b_r[0]) | (br_r & ~(a_r[0] ^ b_r[0]));
    res_next_s = res_r >> 1;
    res_next_s[WIDTH-1] = d_s;
  end

  // Operand shift registers, running borrow and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      br_r  <= 1'b0;
      cnt_r <= '0;
    end else if (load_s) begin
      a_r   <= bus.a;
      b_r   <= bus.b;
      res_r <= '0;
      br_r  <= bus.b_in;
      cnt_r <= '0;
    end else if (shift_s) begin
      a_r   <= a_r >> 1;
      b_r   <= b_r >> 1;
      res_r <= res_next_s;
      br_r  <= br_next_s;
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Published result: written only on the edge entering DONE, so partial sums never show.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_r <= '0;
      bo_r   <= 1'b0;
    end else if (last_s) begin
      diff_r <= res_next_s;
      bo_r   <= br_next_s;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are kept aside because the shift registers lose them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (load_s) begin
      a_msb_r <= bus.a[WIDTH-1];
      b_msb_r <= bus.b[WIDTH-1];
    end else if (last_s) begin
      ovf_r   <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
    end
  end

  assign bus.overflow = ovf_r;
`endif

  // Registered status flags derived from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == SHIFT);
      done_r <= (state_next_s == DONE);
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.difference = diff_r;
  assign bus.b_out      = bo_r;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub -- randomized self-checking bench for serial_sub.
// Runs a WIDTH=8 and a WIDTH=1 instance side by side on shared stimulus
// (the 1-bit instance sees bit 0 of each operand) against an arithmetic
// reference model. SERIAL_SUB_OVF_EN also enables overflow checking.
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(8)) bus8();
  serial_sub_if #(.WIDTH(1)) bus1();

  serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_sub #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  // Reference model state, index 0 = WIDTH 8, index 1 = WIDTH 1.
  int wid [2] = '{8, 1};
  bit acc_valid [2];
  int acc_e  [2];
  int pend_d [2];
  int pend_bo[2];
  int exp_d  [2];
  int exp_bo [2];
`ifdef SERIAL_SUB_OVF_EN
  int pend_ov[2];
  int exp_ov [2];
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d, t=%0t)", tag, got, exp, edge_n, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      acc_valid[i] = 1'b0;
      acc_e[i]     = 0;
      exp_d[i]     = 0;
      exp_bo[i]    = 0;
`ifdef SERIAL_SUB_OVF_EN
      exp_ov[i]    = 0;
`endif
    end
  endtask

  // Reference arithmetic: plain integer subtraction, borrow = negative result.
  task automatic model_accept(input int i, input int av, input int bv, input int bi);
    int w, mask, am, bm, full, half, sa, sb, sres;
    w    = wid[i];
    mask = (1 << w) - 1;
    am   = av & mask;
    bm   = bv & mask;
    full = am - bm - bi;
    pend_d[i]  = full & mask;
    pend_bo[i] = (full < 0) ? 1 : 0;
    half = 1 << (w - 1);
    sa   = (am >= half) ? am - 2 * half : am;
    sb   = (bm >= half) ? bm - 2 * half : bm;
    sres = sa - sb - bi;
`ifdef SERIAL_SUB_OVF_EN
    pend_ov[i] = (sres < -half || sres > half - 1) ? 1 : 0;
`else
    if (sres > 1 << 20) pend_d[i] = pend_d[i];
`endif
    acc_valid[i] = 1'b1;
    acc_e[i]     = edge_n;
  endtask

  // Model one rising edge: an operation started at edge k finishes at edge k+W;
  // a start seen while shifting (edges k+1..k+W) is ignored.
  task automatic model_edge(input bit s, input int av, input int bv, input int bi);
    for (int i = 0; i < 2; i++) begin
      bit shifting;
      if (acc_valid[i] && edge_n == acc_e[i] + wid[i]) begin
        exp_d[i]  = pend_d[i];
        exp_bo[i] = pend_bo[i];
`ifdef SERIAL_SUB_OVF_EN
        exp_ov[i] = pend_ov[i];
`endif
      end
      shifting = acc_valid[i] && (edge_n > acc_e[i]) && (edge_n <= acc_e[i] + wid[i]);
      if (s && !shifting) model_accept(i, av, bv, bi);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic       g_busy, g_done, g_bo;
      logic [7:0] g_d;
      int         e_busy, e_done;
      if (i == 0) begin
        g_busy = bus8.busy; g_done = bus8.done; g_d = bus8.difference; g_bo = bus8.b_out;
      end else begin
        g_busy = bus1.busy; g_done = bus1.done; g_d = {7'd0, bus1.difference}; g_bo = bus1.b_out;
      end
      e_busy = (acc_valid[i] && edge_n >= acc_e[i] && edge_n < acc_e[i] + wid[i]) ? 1 : 0;
      e_done = (acc_valid[i] && edge_n == acc_e[i] + wid[i]) ? 1 : 0;
      check_eq($sformatf("busy_w%0d", wid[i]), 32'(g_busy), 32'(e_busy));
      check_eq($sformatf("done_w%0d", wid[i]), 32'(g_done), 32'(e_done));
      check_eq($sformatf("difference_w%0d", wid[i]), 32'(g_d), 32'(exp_d[i]));
      check_eq($sformatf("b_out_w%0d", wid[i]), 32'(g_bo), 32'(exp_bo[i]));
`ifdef SERIAL_SUB_OVF_EN
      if (i == 0) check_eq("overflow_w8", 32'(bus8.overflow), 32'(exp_ov[0]));
      else        check_eq("overflow_w1", 32'(bus1.overflow), 32'(exp_ov[1]));
`endif
    end
  endtask

  // Drive at the falling edge, let the rising edge sample, check at the next falling edge.
  task automatic step(input bit s, input logic [7:0] av, input logic [7:0] bv, input bit bi);
    bus8.start = s; bus8.a = av;    bus8.b = bv;    bus8.b_in = bi;
    bus1.start = s; bus1.a = av[0]; bus1.b = bv[0]; bus1.b_in = bi;
    @(posedge clk);
    edge_n++;
    model_edge(s, int'(av), int'(bv), int'(bi));
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  // Asynchronous reset between clock edges: outputs must clear before any edge.
  task automatic reset_mid();
    bus8.start = 1'b0;
    bus1.start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.b_in = 1'b0;
    bus1.start = 1'b0; bus1.a = 1'b0;  bus1.b = 1'b0;  bus1.b_in = 1'b0;

    // Reset state.
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Basic and borrow/overflow directed cases.
    step(1'b1, 8'h35, 8'h12, 1'b0); idle(10);
    step(1'b1, 8'h00, 8'h01, 1'b1); idle(10);
    step(1'b1, 8'h80, 8'h01, 1'b0); idle(10);

    // Re-pulsed start during shifting must be ignored.
    step(1'b1, 8'h5A, 8'h13, 1'b1);
    idle(2);
    step(1'b1, 8'hFF, 8'h01, 1'b0);
    idle(9);

    // Reset mid-operation, then a fresh operation.
    step(1'b1, 8'hC3, 8'h3C, 1'b0);
    idle(3);
    reset_mid();
    idle(2);
    step(1'b1, 8'h77, 8'h99, 1'b1); idle(10);

    // Start held high continuously.
    for (int k = 0; k < 40; k++) step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    idle(10);

    // Full-subtractor truth table on the 1-bit instance.
    for (int k = 0; k < 8; k++) begin
      logic [7:0] av, bv;
      av = 8'($urandom);
      bv = 8'($urandom);
      av[0] = k[2];
      bv[0] = k[1];
      step(1'b1, av, bv, k[0]);
      idle(9);
    end

    // Random traffic.
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 2) == 0, 8'($urandom), 8'($urandom), 1'($urandom));
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a subtraction; sampled on a rising clk edge.
REQ-005 SHALL have port a  input  WIDTH  minuend; captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; captured when start is accepted.
REQ-007 SHALL have port b_in  input  1  borrow-in; captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse; high in the cycle a result becomes valid.
REQ-010 SHALL have port difference  output  WIDTH  result a - b - b_in, modulo 2^WIDTH.
REQ-011 SHALL have port b_out  output  1  borrow-out of the MSB stage.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 Transitions SHALL be: IDLE->SHIFT on start; SHIFT->DONE after WIDTH shift cycles; DONE->SHIFT on start, else DONE->IDLE.
REQ-014 On start acceptance, a, b and b_in SHALL be latched into two shift registers and a borrow flop, and the bit counter SHALL clear to 0.
REQ-015 Each SHIFT cycle SHALL process one bit, LSB first: d = a0^b0^br; br_next = (~a0&b0) | (br&~(a0^b0)).
REQ-016 Each d SHALL shift into the MSB of an internal result register; the operand registers SHALL shift right by one.
REQ-017 If start is sampled at edge k, the WIDTH shift edges SHALL be k+1..k+WIDTH, and done SHALL be high for exactly one cycle after edge k+WIDTH.
REQ-018 busy SHALL be high exactly while the FSM is in SHIFT; it SHALL be low in IDLE and DONE.
REQ-019 start asserted while busy SHALL be ignored; it SHALL NOT alter operands, counter or outputs.
REQ-020 start asserted in DONE SHALL be accepted, allowing back-to-back operations with one done cycle between them.
REQ-021 difference and b_out SHALL update only on the edge entering DONE, and SHALL hold that value until the next completion.
REQ-022 Intermediate shift contents SHALL never appear on difference.
REQ-023 The counter SHALL be sized to hold WIDTH; WIDTH=1 SHALL complete in one shift cycle.

Reset
REQ-024 rst high SHALL immediately force the FSM to IDLE, whatever clk is doing.
REQ-025 rst high SHALL force busy=0, done=0, difference=0, b_out=0, all shift registers, the borrow flop and the counter to 0.
REQ-026 Reset during SHIFT SHALL abort the operation with no done pulse; the first operation after release requires a fresh start.

Configuration
REQ-027 The macro SERIAL_SUB_OVF_EN SHALL control a signed-overflow output.
REQ-028 With SERIAL_SUB_OVF_EN defined, the block SHALL add port overflow  output  1, and overflow SHALL update with difference.
REQ-029 The overflow condition SHALL be: a[MSB] != b[MSB] and difference[MSB] != a[MSB], using the latched operands.
REQ-030 overflow SHALL reset to 0.
REQ-031 With SERIAL_SUB_OVF_EN undefined, the overflow port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 WIDTH=8, a=0x35, b=0x12, b_in=0, start at edge 0 -> done at cycle 8 only, difference=0x23, b_out=0, busy high for 8 cycles.
REQ-033 WIDTH=8, a=0x00, b=0x01, b_in=1 -> difference=0xFE, b_out=1; with OVF_EN, a=0x80, b=0x01, b_in=0 -> difference=0x7F, overflow=1.
REQ-034 Start re-pulsed at cycle 3 with new operands -> ignored; result equals the first operation's values, one done pulse.
REQ-035 rst asserted mid-SHIFT (cycle 4) -> outputs 0 immediately, no done; a new start after release yields the correct result.
REQ-036 Start held high continuously -> the first done occurs after WIDTH shifts, then an operation completes every WIDTH+1 cycles with correct results.
REQ-037 WIDTH=1, all 8 combinations of a, b and b_in -> difference and b_out match the 1-bit full-subtractor truth table, done one cycle after start.
